lbp_window_sched: RTL and testbench

- Sequencing controller for the LBP engine on a 128x128 grayscale frame.
- Rasters the 3x3 neighbourhood over every interior pixel and drives the gray-memory request port (gray_req/gray_addr).
- Tells the window/compare datapath when to shift and load pixels, then issues lbp_valid/lbp_addr writes and finish.
- Reuses columns: one column load (3 fetches) per output pixel in steady state.

---
 rtl/lbp_pkg.sv | 25 ++
 rtl/lbp_window_sched_if.sv | 40 ++++
 rtl/lbp_raster_cnt.sv | 46 ++++
 rtl/lbp_window_sched.sv | 116 +++++++++++
 tb/tb_lbp_window_sched.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lbp_pkg.sv
// LBP window scheduler shared definitions.
// Frame geometry, FSM states and pixel address helper.
package lbp_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;
  localparam int XW     = $clog2(IMG_W);
  localparam int YW     = $clog2(IMG_H);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    SHIFT,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] pix_addr(
    input logic [YW-1:0] row,
    input logic [XW-1:0] col
  );
    return ADDR_W'(row) * ADDR_W'(IMG_W) + ADDR_W'(col);
  endfunction

endpackage

// File: rtl/lbp_window_sched_if.sv
// Gray-memory request, window datapath and LBP write bundle.
// The scheduler is the master; memory/datapath side is the slave.
interface lbp_window_sched_if;
  import lbp_pkg::*;

  logic              gray_ready;
  logic              gray_req;
  logic [ADDR_W-1:0] gray_addr;
  logic              pix_we;
  logic [1:0]        pix_row;
  logic              win_shift;
  logic              lbp_valid;
  logic [ADDR_W-1:0] lbp_addr;
  logic              finish;

  modport master (
    input  gray_ready,
    output gray_req,
    output gray_addr,
    output pix_we,
    output pix_row,
    output win_shift,
    output lbp_valid,
    output lbp_addr,
    output finish
  );

  modport slave (
    output gray_ready,
    input  gray_req,
    input  gray_addr,
    input  pix_we,
    input  pix_row,
    input  win_shift,
    input  lbp_valid,
    input  lbp_addr,
    input  finish
  );

endinterface

// File: rtl/lbp_raster_cnt.sv
// Window centre counters and fetch index within the window.
// col_idx stays at 2 between windows so SHIFT loads only column x+1.
module lbp_raster_cnt
  import lbp_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          adv,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [1:0]    col_idx,
  output logic [1:0]    row_idx,
  output logic          last_fetch_of_col,
  output logic          last_col_of_row,
  output logic          last_row
);

  assign last_fetch_of_col = row_idx == 2'd2;
  assign last_col_of_row   = x == XW'(IMG_W - 2);
  assign last_row          = y == YW'(IMG_H - 2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x       <= XW'(1);
      y       <= YW'(1);
      col_idx <= 2'd0;
      row_idx <= 2'd0;
    end else if (adv) begin
      if (!last_fetch_of_col) begin
        row_idx <= row_idx + 2'd1;
      end else begin
        row_idx <= 2'd0;
        if (col_idx != 2'd2) begin
          col_idx <= col_idx + 2'd1;
        end else if (last_col_of_row) begin
          x       <= XW'(1);
          col_idx <= 2'd0;
          if (!last_row) y <= y + YW'(1);
        end else begin
          x <= x + XW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/lbp_window_sched.sv
// LBP 3x3 window sequencer: fetch order, datapath strobes,
// LBP write strobes and frame completion.
module lbp_window_sched
  import lbp_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  lbp_window_sched_if.master  bus
);

  state_t            state;
  state_t            state_nx;
  logic              issue;
  logic              win_done;
  logic [XW-1:0]     x;
  logic [YW-1:0]     y;
  logic [1:0]        col_idx;
  logic [1:0]        row_idx;
  logic              last_fetch_of_col;
  logic              last_col_of_row;
  logic              last_row;
  logic [YW-1:0]     row;
  logic [XW-1:0]     col;
  logic [1:0]        req_row;
  logic              req_last;
  logic              we_last;
  logic [ADDR_W-1:0] we_addr;

  lbp_raster_cnt u_cnt (
    .clk               (clk),
    .reset             (reset),
    .adv               (issue),
    .x                 (x),
    .y                 (y),
    .col_idx           (col_idx),
    .row_idx           (row_idx),
    .last_fetch_of_col (last_fetch_of_col),
    .last_col_of_row   (last_col_of_row),
    .last_row          (last_row)
  );

  assign win_done = last_fetch_of_col && col_idx == 2'd2;
  assign row = y - YW'(1) + YW'(row_idx);
  assign col = x - XW'(1) + XW'(col_idx);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.gray_ready) begin
          issue    = 1'b1;
          state_nx = FILL;
        end
      end
      FILL, SHIFT: begin
        if (bus.gray_ready) begin
          issue = 1'b1;
          if (win_done) begin
            unique case (1'b1)
              !last_col_of_row:
                state_nx = SHIFT;
              last_col_of_row && !last_row:
                state_nx = FILL;
              last_col_of_row && last_row:
                state_nx = DONE;
              default:
                state_nx = state;
            endcase
          end
        end
      end
      default: state_nx = state;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      req_row       <= 2'd0;
      req_last      <= 1'b0;
      we_last       <= 1'b0;
      we_addr       <= '0;
      bus.gray_req  <= 1'b0;
      bus.gray_addr <= '0;
      bus.pix_we    <= 1'b0;
      bus.pix_row   <= 2'd0;
      bus.win_shift <= 1'b0;
      bus.lbp_valid <= 1'b0;
      bus.lbp_addr  <= '0;
      bus.finish    <= 1'b0;
    end else begin
      state        <= state_nx;
      bus.gray_req <= issue;
      if (issue) begin
        bus.gray_addr <= pix_addr(row, col);
        req_row       <= row_idx;
        req_last      <= win_done;
      end
      bus.pix_we    <= bus.gray_req;
      bus.win_shift <= bus.gray_req && req_row == 2'd0;
      if (bus.gray_req) begin
        bus.pix_row <= req_row;
        we_addr     <= bus.gray_addr;
      end
      we_last       <= bus.gray_req && req_last;
      bus.lbp_valid <= we_last;
      // last fetch is (y+1, x+1); centre sits one row up, one col left
      if (we_last)
        bus.lbp_addr <= we_addr - ADDR_W'(IMG_W + 1);
      bus.finish <= bus.finish ||
                    (bus.lbp_valid && state == DONE);
    end
  end

endmodule

// File: tb/tb_lbp_window_sched.sv
// Bench for lbp_window_sched: frame-order request model,
// golden LBP datapath, stalls and mid-frame reset.
module tb_lbp_window_sched;
  import lbp_pkg::*;

  localparam int NPIX = IMG_W * IMG_H;
  localparam int NWIN = (IMG_W - 2) * (IMG_H - 2);

  typedef struct {
    int addr;
    int row;
    bit done;
    int ctr;
  } req_t;

  typedef logic [8:0][7:0] win_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  lbp_window_sched_if bus();

  lbp_window_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input int act,
                     input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] lbp_code(input win_t w);
    int ord[8] = '{0, 1, 2, 5, 8, 7, 6, 3};
    logic [7:0] c;
    for (int b = 0; b < 8; b++)
      c[b] = w[ord[b]] >= w[4];
    return c;
  endfunction

  function automatic win_t upd(input win_t w, input logic sh,
                               input logic [1:0] r,
                               input logic [7:0] d);
    win_t n = w;
    if (sh)
      for (int i = 0; i < 3; i++) begin
        n[i*3]   = w[i*3+1];
        n[i*3+1] = w[i*3+2];
      end
    n[int'(r)*3+2] = d;
    return n;
  endfunction

  logic [7:0] img [NPIX];
  logic [7:0] outm [NPIX] = '{default: 8'd0};
  logic [7:0] gd = 8'd0;
  win_t       win = '0;
  bit         mem_en = 1'b0;

  function automatic logic [7:0] gold(input int y, input int x);
    win_t g;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        g[r*3+c] = img[(y-1+r)*IMG_W + x-1+c];
    return lbp_code(g);
  endfunction

  // memory with one-cycle read latency plus the window datapath
  always @(posedge clk) begin
    if (bus.gray_req) gd <= img[bus.gray_addr];
    if (bus.pix_we)
      win <= upd(win, bus.win_shift, bus.pix_row, gd);
    if (mem_en && bus.lbp_valid)
      outm[bus.lbp_addr] <= lbp_code(win);
  end

  req_t q[$];
  req_t pr;
  req_t pw;
  req_t e;
  bit   pr_v, pw_v, fin_p, exp_req, built, chk_en;
  int   nlbp, n_dut_lbp, last_lbp;
  logic rdy_q = 1'b0;

  always @(posedge clk) rdy_q <= bus.gray_ready;

  always @(negedge clk) begin
    if (!chk_en) begin
      if (!built) begin
        q.delete();
        for (int y = 1; y <= IMG_H-2; y++)
          for (int x = 1; x <= IMG_W-2; x++)
            for (int c = (x == 1 ? 0 : x+1); c <= x+1; c++)
              for (int r = 0; r < 3; r++) begin
                e.addr = (y-1+r)*IMG_W + c;
                e.row  = r;
                e.done = (r == 2) && (c == x+1);
                e.ctr  = y*IMG_W + x;
                q.push_back(e);
              end
        pr_v = 0; pw_v = 0; fin_p = 0;
        nlbp = 0; n_dut_lbp = 0; last_lbp = 0;
        built = 1;
      end
    end else begin
      built = 0;
      exp_req = rdy_q && q.size() > 0;
      chk("gray_req", int'(bus.gray_req), int'(exp_req));
      if (exp_req) begin
        e = q.pop_front();
        if (bus.gray_req)
          chk("gray_addr", int'(bus.gray_addr), e.addr);
      end
      chk("pix_we", int'(bus.pix_we), int'(pr_v));
      if (pr_v && bus.pix_we) begin
        chk("pix_row", int'(bus.pix_row), pr.row);
        chk("win_shift", int'(bus.win_shift),
            int'(pr.row == 0));
      end
      chk("lbp_valid", int'(bus.lbp_valid),
          int'(pw_v && pw.done));
      if (bus.lbp_valid) begin
        n_dut_lbp++;
        last_lbp = int'(bus.lbp_addr);
      end
      if (pw_v && pw.done) begin
        nlbp++;
        if (bus.lbp_valid)
          chk("lbp_addr", int'(bus.lbp_addr), pw.ctr);
      end
      chk("finish", int'(bus.finish), int'(fin_p));
      if (pw_v && pw.done && nlbp == NWIN) fin_p = 1;
      pw_v = pr_v;
      pw   = pr;
      pr_v = exp_req;
      pr   = e;
    end
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_gray_req"},  int'(bus.gray_req),  0);
    chk({tag, "_gray_addr"}, int'(bus.gray_addr), 0);
    chk({tag, "_pix_we"},    int'(bus.pix_we),    0);
    chk({tag, "_pix_row"},   int'(bus.pix_row),   0);
    chk({tag, "_win_shift"}, int'(bus.win_shift), 0);
    chk({tag, "_lbp_valid"}, int'(bus.lbp_valid), 0);
    chk({tag, "_lbp_addr"},  int'(bus.lbp_addr),  0);
    chk({tag, "_finish"},    int'(bus.finish),    0);
  endtask

  int   exp_a[12] = '{0, 128, 256, 1, 129, 257,
                      2, 130, 258, 3, 131, 259};
  logic lg_req[21];
  int   lg_addr[21];
  logic lg_we[21];
  int   lg_row[21];
  logic lg_sh[21];
  logic lg_v[21];
  int   lg_la[21];
  bit   found;
  int   gap;

  initial begin
    chk_en = 0;
    bus.gray_ready = 1'b0;
    for (int i = 0; i < NPIX; i++) img[i] = 8'($urandom);
    repeat (3) @(negedge clk);
    #2 chk_zero("reset");
    reset = 1'b1;
    @(negedge clk);
    #2 chk_en = 1;
    bus.gray_ready = 1'b1;

    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      lg_req[k]  = bus.gray_req;
      lg_addr[k] = int'(bus.gray_addr);
      lg_we[k]   = bus.pix_we;
      lg_row[k]  = int'(bus.pix_row);
      lg_sh[k]   = bus.win_shift;
      lg_v[k]    = bus.lbp_valid;
      lg_la[k]   = int'(bus.lbp_addr);
    end
    for (int k = 1; k <= 12; k++) begin
      chk("start_req", int'(lg_req[k]), 1);
      chk("start_addr", lg_addr[k], exp_a[k-1]);
    end
    for (int k = 2; k <= 13; k++) begin
      chk("start_we", int'(lg_we[k]), 1);
      chk("start_row", lg_row[k], (k-2) % 3);
      chk("start_shift", int'(lg_sh[k]), int'((k-2) % 3 == 0));
    end
    for (int k = 1; k <= 15; k++)
      chk("start_valid", int'(lg_v[k]), int'(k == 11 || k == 14));
    chk("start_la11", lg_la[11], 129);
    chk("start_la14", lg_la[14], 130);

    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      found = bus.lbp_valid && bus.lbp_addr == 14'd254;
    end
    chk("wrap_found", int'(found), 1);
    chk("wrap_req_addr", int'(bus.gray_addr), 256);
    gap = 0;
    found = 0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      gap++;
      found = bus.lbp_valid;
    end
    chk("wrap_gap", gap, 9);
    chk("wrap_next_addr", int'(bus.lbp_addr), 257);

    found = 0;
    for (int i = 0; i < 20000 && !found; i++) begin
      @(negedge clk);
      found = bus.lbp_valid &&
              int'(bus.lbp_addr) == 40*IMG_W + 60;
    end
    chk("row40_found", int'(found), 1);
    #2 reset = 1'b0;
    chk_en = 0;
    bus.gray_ready = 1'b0;
    #1 chk_zero("midrst");

    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    mem_en = 1'b1;
    @(negedge clk);
    #2 chk_en = 1;
    bus.gray_ready = 1'b1;

    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      found = bus.gray_req && bus.gray_addr == 14'd131;
    end
    chk("stall_found", int'(found), 1);
    #2 bus.gray_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_req", int'(bus.gray_req), 0);
      if (i == 0) begin
        chk("stall_we", int'(bus.pix_we), 1);
        chk("stall_row", int'(bus.pix_row), 1);
      end
    end
    #2 bus.gray_ready = 1'b1;
    @(negedge clk);
    chk("resume_req", int'(bus.gray_req), 1);
    chk("resume_addr", int'(bus.gray_addr), 259);

    found = 0;
    for (int i = 0; i < 80000 && !found; i++) begin
      @(negedge clk);
      found = bus.finish;
      #2 bus.gray_ready = $urandom_range(99) >= 8;
    end
    chk("finish_seen", int'(found), 1);
    repeat (10) begin
      @(negedge clk);
      #2 bus.gray_ready = 1'($urandom);
    end
    chk("lbp_count", n_dut_lbp, NWIN);
    chk("last_lbp_addr", last_lbp, 16254);
    for (int a = 0; a < NPIX; a++) begin
      if (a / IMG_W == 0 || a / IMG_W == IMG_H-1 ||
          a % IMG_W == 0 || a % IMG_W == IMG_W-1)
        chk("mem_border", int'(outm[a]), 0);
      else
        chk("mem_lbp", int'(outm[a]),
            int'(gold(a / IMG_W, a % IMG_W)));
    end
    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
